mem_cmd_sequencer: RTL

Sequences and arbitrates the CPU's single memory command channel (cmd_stb/cmd_word/cmd_busy, rsp_stb/rsp_word) between the instruction-fetch port and the data load/store port of the multi-cycle core. For each request it issues a set-address command and then a read or write command to the wishbone master. It waits for the response and returns read data with a one-cycle done pulse. It sits between riscv_multi's controller/datapath and the wishbone master.

---
 rtl/mem_cmd_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: arbitrates fetch and data requests onto a single memory
// command channel. Each request issues set-address then read/write, waits
// for the response and returns a one-cycle done pulse on the winning port.
// Optional feature: define MEM_SEQ_ADDR_REUSE_EN to skip the set-address
// command when the word address matches the last one sent.
module mem_cmd_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        cmd_stb,
  output logic [33:0] cmd_word,
  input  logic        cmd_busy,
  input  logic        rsp_stb,
  input  logic [33:0] rsp_word,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StAddr, StOp, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        cmd_stb_d;
  logic [33:0] cmd_word_d;
  logic        latch_req;

  // Request captured at arbitration time
  logic        sel_data_q;
  logic        we_q;
  logic [31:0] wdata_q;

  // Arbitration result: data port has fixed priority over fetch
  logic        any_req;
  logic        win_data;
  logic        win_we;
  logic [29:0] win_waddr;
  logic        reuse_hit;

  assign any_req   = d_req | if_req;
  assign win_data  = d_req;
  assign win_we    = d_req & d_we;
  assign win_waddr = d_req ? d_addr[31:2] : if_addr[31:2];

  // Byte-offset and response tag bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{rsp_word[33:32], if_addr[1:0], d_addr[1:0]};

  function automatic logic [33:0] op_word(input logic we, input logic [31:0] wdata);
    return we ? {2'b01, wdata} : {2'b00, 32'h0};
  endfunction

`ifdef MEM_SEQ_ADDR_REUSE_EN
  logic [29:0] last_waddr_q;
  logic        last_valid_q;

  assign reuse_hit = last_valid_q && (win_waddr == last_waddr_q);

  // Track the address most recently accepted by the master
  always_ff @(posedge clk) begin
    if (reset) begin
      last_waddr_q <= '0;
      last_valid_q <= 1'b0;
    end else if (state_q == StAddr && !cmd_busy) begin
      last_waddr_q <= cmd_word[29:0];
      last_valid_q <= 1'b1;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  // Next-state and next command word
  always_comb begin
    state_d    = state_q;
    cmd_stb_d  = cmd_stb;
    cmd_word_d = cmd_word;
    latch_req  = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_stb_d  = 1'b0;
        cmd_word_d = '0;
        if (any_req) begin
          latch_req = 1'b1;
          cmd_stb_d = 1'b1;
          if (reuse_hit) begin
            state_d    = StOp;
            cmd_word_d = op_word(win_we, d_wdata);
          end else begin
            state_d    = StAddr;
            cmd_word_d = {2'b10, 1'b0, 1'b0, win_waddr};
          end
        end
      end
      StAddr: begin
        if (!cmd_busy) begin
          state_d    = StOp;
          cmd_stb_d  = 1'b1;
          cmd_word_d = op_word(we_q, wdata_q);
        end
      end
      StOp: begin
        if (!cmd_busy) begin
          state_d    = StWait;
          cmd_stb_d  = 1'b0;
          cmd_word_d = '0;
        end
      end
      StWait: begin
        if (rsp_stb) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: begin
        state_d    = StIdle;
        cmd_stb_d  = 1'b0;
        cmd_word_d = '0;
      end
    endcase
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_stb  <= 1'b0;
      cmd_word <= '0;
    end else begin
      state_q  <= state_d;
      cmd_stb  <= cmd_stb_d;
      cmd_word <= cmd_word_d;
    end
  end

  // Capture the winning request; later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else if (latch_req) begin
      sel_data_q <= win_data;
      we_q       <= win_we;
      wdata_q    <= d_wdata;
    end
  end

  // Read data lands in the winning port's register only on a read response
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state_q == StWait && rsp_stb && !we_q) begin
      if (sel_data_q) d_rdata  <= rsp_word[31:0];
      else            if_rdata <= rsp_word[31:0];
    end
  end

  assign if_done = (state_q == StDone) && !sel_data_q;
  assign d_done  = (state_q == StDone) && sel_data_q;
  assign busy    = (state_q != StIdle);

endmodule
